// File: rtl/divider_pkg.sv
// Shared types and helpers for the sequential restoring divider.
// The magnitude helper supports operand widths up to MAX_W bits.
package divider_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    FIXUP = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam int MAX_W = 64;
  localparam int IW    = $clog2(MAX_W);

  // Two's-complement magnitude of the low w bits of v; bits above w are cleared.
  function automatic logic [MAX_W-1:0] twos_mag(input logic [MAX_W-1:0] v, input int w);
    logic [MAX_W-1:0] mask;
    mask = (w >= MAX_W) ? '1 : ((MAX_W'(1) << w) - MAX_W'(1));
    if (v[IW'(w - 1)]) return (~v + MAX_W'(1)) & mask;
    return v & mask;
  endfunction

endpackage

// File: rtl/div_step.sv
// One restoring-division iteration: shift the next dividend bit into the
// partial remainder, trial-subtract the divisor, keep or restore.
module div_step #(
  parameter int N = 8
) (
  input  logic [N-2:0] r_low,
  input  logic         a_msb,
  input  logic [N-1:0] b,
  output logic [N-1:0] r_out,
  output logic         q_bit
);

  logic [N-1:0] shifted;
  logic [N:0]   trial;

  // The partial remainder stays below the divisor, so its top bit never
  // carries information into the shifted value.
  assign shifted = {r_low, a_msb};
  assign trial   = {1'b0, shifted} - {1'b0, b};
  assign q_bit   = ~trial[N];
  assign r_out   = trial[N] ? shifted : trial[N-1:0];

endmodule

// File: rtl/seq_divider_gen.sv
// Multi-cycle restoring divider, one quotient bit per clock, valid/ready on
// both sides. Define SIGNED_DIV_EN to add the Signed port and the FIXUP state.
module seq_divider_gen
  import divider_pkg::*;
#(
  parameter int N = 8
) (
  input  logic         Clock,
  input  logic         Reset,
  input  logic         InValid,
  output logic         InReady,
  input  logic [N-1:0] DataA,
  input  logic [N-1:0] DataB,
  output logic         OutValid,
  input  logic         OutReady,
  output logic [N-1:0] Q,
  output logic [N-1:0] R,
  output logic         DivZero
`ifdef SIGNED_DIV_EN
  ,
  input  logic         Signed
`endif
);

  localparam int CW = $clog2(N);

  state_t        state;
  logic [N-1:0]  quo;
  logic [N-1:0]  rem;
  logic [N-1:0]  dvs;
  logic [CW-1:0] cnt;
  logic          in_ready;
  logic          out_valid;
  logic          div_zero;
  logic [N-1:0]  step_r;
  logic          step_q;

`ifdef SIGNED_DIV_EN
  logic neg_q;
  logic neg_r;
  logic a_neg;
  logic b_neg;

  assign a_neg = Signed & DataA[N-1];
  assign b_neg = Signed & DataB[N-1];
`endif

  div_step #(.N(N)) u_step (
    .r_low (rem[N-2:0]),
    .a_msb (quo[N-1]),
    .b     (dvs),
    .r_out (step_r),
    .q_bit (step_q)
  );

  // NOTE: every register here is updated with <= so all of them see the
  // pre-edge values of each other within one clock.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      state     <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      quo       <= '0;
      rem       <= '0;
      dvs       <= '0;
      cnt       <= '0;
      div_zero  <= 1'b0;
`ifdef SIGNED_DIV_EN
      neg_q     <= 1'b0;
      neg_r     <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (InValid) begin
            in_ready <= 1'b0;
            cnt      <= CW'(N - 1);
            div_zero <= 1'b0;
            dvs      <= DataB;
            if (DataB == '0) begin
              // Divide-by-zero skips RUN; DONE raises OutValid one edge later.
              quo      <= '1;
              rem      <= DataA;
              div_zero <= 1'b1;
              state    <= DONE;
            end else begin
              rem   <= '0;
              state <= RUN;
`ifdef SIGNED_DIV_EN
              quo   <= a_neg ? N'(twos_mag(MAX_W'(DataA), N)) : DataA;
              dvs   <= b_neg ? N'(twos_mag(MAX_W'(DataB), N)) : DataB;
              neg_q <= a_neg ^ b_neg;
              neg_r <= a_neg;
`else
              quo   <= DataA;
`endif
            end
          end
        end

        RUN: begin
          rem <= step_r;
          quo <= {quo[N-2:0], step_q};
          if (cnt == '0) begin
`ifdef SIGNED_DIV_EN
            state     <= FIXUP;
`else
            state     <= DONE;
            out_valid <= 1'b1;
`endif
          end else begin
            cnt <= cnt - 1'b1;
          end
        end

`ifdef SIGNED_DIV_EN
        FIXUP: begin
          if (neg_q) quo <= -quo;
          if (neg_r) rem <= -rem;
          state     <= DONE;
          out_valid <= 1'b1;
        end
`endif

        DONE: begin
          if (!out_valid) begin
            out_valid <= 1'b1;
          end else if (OutReady) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

  assign InReady  = in_ready;
  assign OutValid = out_valid;
  assign Q        = quo;
  assign R        = rem;
  assign DivZero  = div_zero;

endmodule
